vga_timing_ctrl: RTL
====================

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 Parameter WIDTH_PX, default 640, active pixels per line.
REQ-002 Parameter HEIGHT_LNS, default 480, active lines per frame.
REQ-003 Parameters H_SYNC_PX, H_B_PORCH_PX and H_F_PORCH_PX, defaults 96, 48 and 16, are the horizontal sync, back-porch and front-porch pixel counts.
REQ-004 Parameters V_SYNC_LNS, V_B_PORCH_LNS and V_F_PORCH_LNS, defaults 2, 33 and 10, are the vertical sync, back-porch and front-porch line counts.
REQ-005 Parameters H_SYNC_POL and V_SYNC_POL, default 0, are the sync active levels (0 = active-low).
REQ-006 Parameter TILE_WIDTH, default 4, is the tile edge in pixels; WIDTH_PX and HEIGHT_LNS SHALL be divisible by it (elaboration-time check).
REQ-007 Derived widths: PXL_CTR_WIDTH = $clog2(H total), LN_CTR_WIDTH = $clog2(V total), X_WIDTH = $clog2(WIDTH_PX), Y_WIDTH = $clog2(HEIGHT_LNS).
REQ-008 clk_i  in  1  pixel clock; single clock domain.
REQ-009 rstn_i  in  1  reset, asynchronous, active-low.
REQ-010 en_i  in  1  pixel strobe; counters advance only when high.
REQ-011 pxl_cntr_o  out  PXL_CTR_WIDTH  horizontal counter.
REQ-012 ln_cntr_o  out  LN_CTR_WIDTH  vertical counter.
REQ-013 hsync_o and vsync_o  out  1 each  sync outputs.
REQ-014 disp_en_o  out  1  active-video flag.
REQ-015 disp_x_o  out  X_WIDTH and disp_y_o  out  Y_WIDTH  active pixel coordinates; both SHALL be 0 outside active video.
REQ-016 tile_x_o and tile_y_o  out  coordinate widths  disp_x_o/TILE_WIDTH and disp_y_o/TILE_WIDTH.
REQ-017 fill_req_o  out  1  one-cycle pulse requesting a line-buffer fill for the next line.
REQ-018 fill_ln_o  out  Y_WIDTH  active-line index of the line to fill; holds its value between pulses.
REQ-019 frame_start_o  out  1  one-cycle pulse on frame wrap.
REQ-020 frame_cntr_o  out  16  frame count.

Function
REQ-021 Horizontal order per line SHALL be: sync [0, H_SYNC_PX), back porch, active [H_SYNC_PX+H_B_PORCH_PX, +WIDTH_PX), front porch; the vertical order is the same.
REQ-022 On a cycle with en_i=1, pxl_cntr increments and SHALL wrap from H total-1 to 0.
REQ-023 On that wrap, ln_cntr increments and SHALL wrap from V total-1 to 0.
REQ-024 With en_i=0, all outputs SHALL hold, and pulses SHALL deassert after their single cycle.
REQ-025 All outputs SHALL be registered and decoded from next-state counters, so sync/disp/coordinate outputs align with pxl_cntr_o/ln_cntr_o in the same cycle (zero skew).
REQ-026 hsync_o SHALL equal H_SYNC_POL while pxl_cntr_o < H_SYNC_PX, and ~H_SYNC_POL otherwise; vsync_o is the same with ln_cntr_o, V_SYNC_LNS and V_SYNC_POL.
REQ-027 disp_en_o SHALL be 1 only when both counters are within their active ranges.
REQ-028 fill_req_o SHALL pulse in the cycle pxl_cntr_o becomes 0 via advance, when ln_cntr_o+1 (mod V total) is an active line; fill_ln_o SHALL equal that line's active index.
REQ-029 frame_start_o SHALL pulse in the cycle the counters become (0,0) via advance; it SHALL NOT pulse on exit from reset.
REQ-030 frame_cntr_o SHALL increment with each frame_start_o and wrap from 0xFFFF to 0.

Reset
REQ-031 While rstn_i=0, all outputs SHALL immediately take these values:
- counters, coordinates, tiles, fill_ln_o and frame_cntr_o = 0;
- disp_en_o, fill_req_o and frame_start_o = 0;
- hsync_o = H_SYNC_POL, vsync_o = V_SYNC_POL.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; counting restarts at (0,0) on the first en_i cycle after release.

Configuration
REQ-033 Macro VGA_TIMING_FRAME_CTR_EN: when defined, frame_cntr_o SHALL follow REQ-030.
REQ-034 When VGA_TIMING_FRAME_CTR_EN is undefined, frame_cntr_o SHALL be tied to 0 with no counter logic; frame_start_o is unaffected.

Verification (default parameters, en_i=1 unless stated)
REQ-035 Release reset -> hsync_o=0 for pxl 0..95 and 1 for pxl 96..799; line period 800 cycles.
REQ-036 Line 34, pxl 0 -> fill_req_o pulses with fill_ln_o=0; line 513 pulses with fill_ln_o=479; no pulse at lines 514..523.
REQ-037 Line 35, pxl 144 -> disp_en_o=1, disp_x_o=0, disp_y_o=0. Line 514, pxl 783 -> x=639, y=479, tile_x=159, tile_y=119. Pxl 784 -> disp_en_o=0, x=y=0.
REQ-038 en_i=0 for 10 cycles at line 100, pxl 300 -> all outputs frozen; advancing resumes at pxl 301.
REQ-039 420000 cycles after release -> counters (0,0), frame_start_o one-cycle pulse, frame_cntr_o=1 with macro and 0 without.
REQ-040 rstn_i low at line 200, pxl 500 -> all outputs take reset values in the same cycle, with no frame_start_o.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster timing generator with line-buffer fill requests.
//
// A horizontal pixel counter and a vertical line counter advance on each
// en_i strobe. All outputs are registered and decoded from the next-state
// counter values, so sync, display-enable and coordinate outputs line up
// with pxl_cntr_o/ln_cntr_o in the same cycle.
//
// Optional feature macro: VGA_TIMING_FRAME_CTR_EN
//   defined   -> frame_cntr_o counts frame_start_o pulses (16-bit, wrapping)
//   undefined -> frame_cntr_o is tied to zero and no counter is built
module vga_timing_ctrl #(
    parameter int unsigned WIDTH_PX      = 640,
    parameter int unsigned HEIGHT_LNS    = 480,
    parameter int unsigned H_SYNC_PX     = 96,
    parameter int unsigned H_B_PORCH_PX  = 48,
    parameter int unsigned H_F_PORCH_PX  = 16,
    parameter int unsigned V_SYNC_LNS    = 2,
    parameter int unsigned V_B_PORCH_LNS = 33,
    parameter int unsigned V_F_PORCH_LNS = 10,
    parameter bit          H_SYNC_POL    = 1'b0,
    parameter bit          V_SYNC_POL    = 1'b0,
    parameter int unsigned TILE_WIDTH    = 4,
    localparam int unsigned H_TOTAL       = H_SYNC_PX + H_B_PORCH_PX + WIDTH_PX + H_F_PORCH_PX,
    localparam int unsigned V_TOTAL       = V_SYNC_LNS + V_B_PORCH_LNS + HEIGHT_LNS + V_F_PORCH_LNS,
    localparam int unsigned PXL_CTR_WIDTH = $clog2(H_TOTAL),
    localparam int unsigned LN_CTR_WIDTH  = $clog2(V_TOTAL),
    localparam int unsigned X_WIDTH       = $clog2(WIDTH_PX),
    localparam int unsigned Y_WIDTH       = $clog2(HEIGHT_LNS)
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     en_i,
    output logic [PXL_CTR_WIDTH-1:0] pxl_cntr_o,
    output logic [LN_CTR_WIDTH-1:0]  ln_cntr_o,
    output logic                     hsync_o,
    output logic                     vsync_o,
    output logic                     disp_en_o,
    output logic [X_WIDTH-1:0]       disp_x_o,
    output logic [Y_WIDTH-1:0]       disp_y_o,
    output logic [X_WIDTH-1:0]       tile_x_o,
    output logic [Y_WIDTH-1:0]       tile_y_o,
    output logic                     fill_req_o,
    output logic [Y_WIDTH-1:0]       fill_ln_o,
    output logic                     frame_start_o,
    output logic [15:0]              frame_cntr_o
);

    // Region boundaries; active windows are half-open [start, end).
    localparam int unsigned H_ACT_START = H_SYNC_PX + H_B_PORCH_PX;
    localparam int unsigned H_ACT_END   = H_ACT_START + WIDTH_PX;
    localparam int unsigned V_ACT_START = V_SYNC_LNS + V_B_PORCH_LNS;
    localparam int unsigned V_ACT_END   = V_ACT_START + HEIGHT_LNS;

    // Tiles must cover the active area exactly; reject bad geometry at elaboration.
    generate
        if (((WIDTH_PX % TILE_WIDTH) != 0) || ((HEIGHT_LNS % TILE_WIDTH) != 0)) begin : g_tile_check
            $error("vga_timing_ctrl: WIDTH_PX and HEIGHT_LNS must be multiples of TILE_WIDTH");
        end
    endgenerate

    logic                     pxl_wrap;
    logic                     ln_wrap;
    logic [PXL_CTR_WIDTH-1:0] pxl_nxt;
    logic [LN_CTR_WIDTH-1:0]  ln_nxt;

    int unsigned              pxl_nxt_w;
    int unsigned              ln_nxt_w;
    int unsigned              ln_ahead;
    logic                     h_act_nxt;
    logic                     v_act_nxt;
    logic                     hsync_nxt;
    logic                     vsync_nxt;
    logic                     disp_en_nxt;
    logic [X_WIDTH-1:0]       disp_x_nxt;
    logic [Y_WIDTH-1:0]       disp_y_nxt;
    logic [X_WIDTH-1:0]       tile_x_nxt;
    logic [Y_WIDTH-1:0]       tile_y_nxt;
    logic                     fill_nxt;
    logic [Y_WIDTH-1:0]       fill_ln_nxt;
    logic                     frame_nxt;

    // Advanced counter values, used only on cycles where en_i is high.
    always_comb begin
        pxl_wrap = (32'(pxl_cntr_o) == (H_TOTAL - 1));
        ln_wrap  = (32'(ln_cntr_o) == (V_TOTAL - 1));
        pxl_nxt  = pxl_cntr_o;
        ln_nxt   = ln_cntr_o;
        if (pxl_wrap) begin
            pxl_nxt = '0;
            ln_nxt  = ln_wrap ? '0 : ln_cntr_o + 1'b1;
        end else begin
            pxl_nxt = pxl_cntr_o + 1'b1;
        end
    end

    // Decode every output from the advanced counters so registers stay aligned.
    always_comb begin
        pxl_nxt_w   = 32'(pxl_nxt);
        ln_nxt_w    = 32'(ln_nxt);
        h_act_nxt   = (pxl_nxt_w >= H_ACT_START) && (pxl_nxt_w < H_ACT_END);
        v_act_nxt   = (ln_nxt_w >= V_ACT_START) && (ln_nxt_w < V_ACT_END);
        hsync_nxt   = (pxl_nxt_w < H_SYNC_PX) ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_nxt   = (ln_nxt_w < V_SYNC_LNS) ? V_SYNC_POL : ~V_SYNC_POL;
        disp_en_nxt = h_act_nxt && v_act_nxt;
        disp_x_nxt  = '0;
        disp_y_nxt  = '0;
        if (disp_en_nxt) begin
            disp_x_nxt = X_WIDTH'(pxl_nxt_w - H_ACT_START);
            disp_y_nxt = Y_WIDTH'(ln_nxt_w - V_ACT_START);
        end
        tile_x_nxt  = X_WIDTH'(32'(disp_x_nxt) / TILE_WIDTH);
        tile_y_nxt  = Y_WIDTH'(32'(disp_y_nxt) / TILE_WIDTH);

        // The fill request looks one line ahead of the line just entered.
        ln_ahead    = (ln_nxt_w == (V_TOTAL - 1)) ? 0 : ln_nxt_w + 1;
        fill_nxt    = pxl_wrap && (ln_ahead >= V_ACT_START) && (ln_ahead < V_ACT_END);
        fill_ln_nxt = Y_WIDTH'(ln_ahead - V_ACT_START);
        frame_nxt   = pxl_wrap && ln_wrap;
    end

    // Timing registers: advance on en_i, hold otherwise; pulses last one cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pxl_cntr_o    <= '0;
            ln_cntr_o     <= '0;
            hsync_o       <= H_SYNC_POL;
            vsync_o       <= V_SYNC_POL;
            disp_en_o     <= 1'b0;
            disp_x_o      <= '0;
            disp_y_o      <= '0;
            tile_x_o      <= '0;
            tile_y_o      <= '0;
            fill_req_o    <= 1'b0;
            fill_ln_o     <= '0;
            frame_start_o <= 1'b0;
        end else begin
            fill_req_o    <= 1'b0;
            frame_start_o <= 1'b0;
            if (en_i) begin
                pxl_cntr_o    <= pxl_nxt;
                ln_cntr_o     <= ln_nxt;
                hsync_o       <= hsync_nxt;
                vsync_o       <= vsync_nxt;
                disp_en_o     <= disp_en_nxt;
                disp_x_o      <= disp_x_nxt;
                disp_y_o      <= disp_y_nxt;
                tile_x_o      <= tile_x_nxt;
                tile_y_o      <= tile_y_nxt;
                fill_req_o    <= fill_nxt;
                frame_start_o <= frame_nxt;
                if (fill_nxt) begin
                    fill_ln_o <= fill_ln_nxt;
                end
            end
        end
    end

`ifdef VGA_TIMING_FRAME_CTR_EN
    // Frame counter steps together with the frame_start_o pulse and wraps naturally.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            frame_cntr_o <= '0;
        end else if (en_i && frame_nxt) begin
            frame_cntr_o <= frame_cntr_o + 16'd1;
        end
    end
`else
    assign frame_cntr_o = '0;
`endif

endmodule
